// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin sharing of one combinational ALU between two
//               valid/ready requesters, with multicycle hold and tagged response.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int MUL_CYC = 2,
    parameter int DIV_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_op1,
    input  logic [WIDTH-1:0] req0_op2,
    input  logic [3:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_op1,
    input  logic [WIDTH-1:0] req1_op2,
    input  logic [3:0]       req1_sel,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_z,
    output logic             rsp_dz
);

    localparam logic [3:0] c_SEL_MUL  = 4'd2;
    localparam logic [3:0] c_SEL_DIV  = 4'd3;
    localparam logic [3:0] c_SEL_NOP  = 4'd7;
    localparam logic [7:0] c_MUL_LOAD = 8'(MUL_CYC - 1);
    localparam logic [7:0] c_DIV_LOAD = 8'(DIV_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last;
    logic             r_id;
    logic [7:0]       r_count;
    logic             r_dz;
    logic             r_nop;
    logic [WIDTH-1:0] r_alu_op1;
    logic [WIDTH-1:0] r_alu_op2;
    logic [3:0]       r_alu_sel;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_res;
    logic             r_rsp_z;
    logic             r_rsp_dz;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_done;
    logic [WIDTH-1:0] w_op1_in;
    logic [WIDTH-1:0] w_op2_in;
    logic [3:0]       w_sel_in;
    logic             w_nop_in;
    logic [7:0]       w_cnt_load;

    // r_last==1 means requester 1 was served last, so requester 0 wins a tie
    assign w_grant0   = req0_valid & (~req1_valid | r_last);
    assign w_grant1   = req1_valid & ~w_grant0;
    assign req0_ready = (r_state == S_IDLE) & w_grant0;
    assign req1_ready = (r_state == S_IDLE) & w_grant1;
    assign w_accept   = req0_ready | req1_ready;

    assign w_op1_in   = w_grant1 ? req1_op1 : req0_op1;
    assign w_op2_in   = w_grant1 ? req1_op2 : req0_op2;
    assign w_sel_in   = w_grant1 ? req1_sel : req0_sel;
    assign w_nop_in   = (w_sel_in == c_SEL_NOP) | w_sel_in[3];
    assign w_cnt_load = w_nop_in                 ? 8'd0 :
                        (w_sel_in == c_SEL_MUL)  ? c_MUL_LOAD :
                        (w_sel_in == c_SEL_DIV)  ? c_DIV_LOAD : 8'd0;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_EXEC;
            S_EXEC: if (r_count == 8'd0) begin
                w_done = 1'b1;
                w_next = S_RESP;
            end
            S_RESP: if (r_rsp_valid & rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last      <= 1'b1;
            r_id        <= 1'b0;
            r_count     <= 8'd0;
            r_dz        <= 1'b0;
            r_nop       <= 1'b0;
            r_alu_op1   <= '0;
            r_alu_op2   <= '0;
            r_alu_sel   <= c_SEL_NOP;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_res   <= '0;
            r_rsp_z     <= 1'b0;
            r_rsp_dz    <= 1'b0;
        end else if (w_accept) begin
            r_alu_op1 <= w_op1_in;
            r_alu_op2 <= w_op2_in;
            r_alu_sel <= w_sel_in;
            r_id      <= w_grant1;
            r_last    <= w_grant1;
            r_count   <= w_cnt_load;
            r_nop     <= w_nop_in;
            r_dz      <= (w_sel_in == c_SEL_DIV) & (w_op2_in == '0);
        end else if (r_state == S_EXEC) begin
            if (!w_done) begin
                r_count <= r_count - 8'd1;
            end else begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_id;
                r_alu_sel   <= c_SEL_NOP;
                // Intercepted ops never look at the ALU outputs
                if (r_nop) begin
                    r_rsp_res <= '0;
                    r_rsp_z   <= 1'b0;
                    r_rsp_dz  <= 1'b0;
                end else if (r_dz) begin
                    r_rsp_res <= '1;
                    r_rsp_z   <= 1'b0;
                    r_rsp_dz  <= 1'b1;
                end else begin
                    r_rsp_res <= alu_res;
                    r_rsp_z   <= alu_z;
                    r_rsp_dz  <= 1'b0;
                end
            end
        end else if ((r_state == S_RESP) && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign alu_op1   = r_alu_op1;
    assign alu_op2   = r_alu_op2;
    assign alu_sel   = r_alu_sel;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_res   = r_rsp_res;
    assign rsp_z     = r_rsp_z;
    assign rsp_dz    = r_rsp_dz;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed plus randomized bench for alu_arbiter with a
//               transaction-level reference model and a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int W  = 32;
    localparam int MC = 2;
    localparam int DC = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [3:0]   req0_sel, req1_sel;
    logic [W-1:0] alu_op1, alu_op2, alu_res;
    logic [3:0]   alu_sel;
    logic         alu_z;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_z, rsp_dz;
    logic [W-1:0] rsp_res;

    int           n_cmp  = 0;
    int           n_fail = 0;
    logic         m_last = 1'b1;
    logic [W-1:0] o_res;
    logic         o_z, o_dz, o_id;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .MUL_CYC(MC), .DIV_CYC(DC)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_sel(req1_sel),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
        .alu_res(alu_res), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_z(rsp_z), .rsp_dz(rsp_dz)
    );

    // Behavioural ALU; junk on divide-by-zero and unused selects
    function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] s);
        logic [W-1:0] r;
        case (s)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a * b;
            4'd3: r = (b == 0) ? 32'h0001_2345 : a / b;
            4'd4: r = a | b;
            4'd5: r = a & b;
            4'd6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'hDEAD_BEEF;
        endcase
        return {(r == 0), r};
    endfunction

    assign {alu_z, alu_res} = alu_f(alu_op1, alu_op2, alu_sel);

    // Expected response {dz, z, res} from the request alone
    function automatic logic [W+1:0] exp_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] s);
        if (s == 4'd7 || s[3]) return '0;
        if (s == 4'd3 && b == 0) return {1'b1, 1'b0, {W{1'b1}}};
        return {1'b0, alu_f(a, b, s)};
    endfunction

    function automatic int lat_f(input logic [3:0] s);
        if (s == 4'd2) return MC;
        if (s == 4'd3) return DC;
        return 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] s);
        if (id) begin
            req1_valid = 1'b1; req1_op1 = a; req1_op2 = b; req1_sel = s;
        end else begin
            req0_valid = 1'b1; req0_op1 = a; req0_op2 = b; req0_sel = s;
        end
    endtask

    // Called just after a negedge with requests driven; returns at a negedge in IDLE
    task automatic serve(input int stall);
        logic         g0, g1, id;
        logic [W-1:0] a, b;
        logic [3:0]   s;
        logic [W+1:0] e;
        int           lat;
        #1;
        g0 = req0_valid & (~req1_valid | m_last);
        g1 = req1_valid & ~g0;
        chk("ready0", req0_ready, g0);
        chk("ready1", req1_ready, g1);
        if (!(g0 | g1)) return;
        id  = g1;
        a   = id ? req1_op1 : req0_op1;
        b   = id ? req1_op2 : req0_op2;
        s   = id ? req1_sel : req0_sel;
        e   = exp_f(a, b, s);
        lat = lat_f(s);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        m_last = id;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            chk("busy_rsp_valid", rsp_valid, 1'b0);
            chk("hold_alu_op1", alu_op1, a);
            chk("hold_alu_op2", alu_op2, b);
            chk("hold_alu_sel", alu_sel, s);
            chk("busy_readys", {req0_ready, req1_ready}, 2'b00);
        end
        @(negedge clk);
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_id", rsp_id, id);
        chk("rsp_res", rsp_res, e[W-1:0]);
        chk("rsp_z", rsp_z, e[W]);
        chk("rsp_dz", rsp_dz, e[W+1]);
        chk("alu_sel_idle", alu_sel, 4'd7);
        chk("resp_readys", {req0_ready, req1_ready}, 2'b00);
        o_res = rsp_res; o_z = rsp_z; o_dz = rsp_dz; o_id = rsp_id;
        rsp_ready = (stall == 0);
        for (int c = 0; c < stall; c++) begin
            @(negedge clk);
            chk("stall_valid", rsp_valid, 1'b1);
            chk("stall_res", rsp_res, e[W-1:0]);
            chk("stall_id", rsp_id, id);
            chk("stall_readys", {req0_ready, req1_ready}, 2'b00);
            if (c == stall - 1) rsp_ready = 1'b1;
        end
        @(negedge clk);
        chk("rsp_released", rsp_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_op1 = '0; req0_op2 = '0; req0_sel = 4'd0;
        req1_valid = 1'b0; req1_op1 = '0; req1_op2 = '0; req1_sel = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_res", rsp_res, '0);
        chk("rst_rsp_flags", {rsp_id, rsp_z, rsp_dz}, 3'b000);
        chk("rst_alu_ops", {alu_op1, alu_op2}, 64'd0);
        chk("rst_alu_sel", alu_sel, 4'd7);
        chk("rst_readys", {req0_ready, req1_ready}, 2'b00);
        @(negedge clk);

        // Tie from reset: REQ0 first, then REQ1, then REQ0 again
        set_req(1'b0, 32'd3, 32'd3, 4'd1);
        set_req(1'b1, 32'd0, 32'd0, 4'd4);
        serve(0);
        chk("t2_first", {o_id, o_z, o_res}, {1'b0, 1'b1, 32'd0});
        set_req(1'b0, 32'd5, 32'd7, 4'd0);
        serve(0);
        chk("t2_second", {o_id, o_z, o_res}, {1'b1, 1'b1, 32'd0});
        set_req(1'b1, 32'd0, 32'd0, 4'd4);
        serve(0);
        chk("t1_add", {o_id, o_z, o_res}, {1'b0, 1'b0, 32'd12});
        serve(0);

        set_req(1'b1, 32'd100, 32'd7, 4'd3);
        serve(0);
        chk("t3_div", {o_dz, o_res}, {1'b0, 32'd14});
        set_req(1'b1, 32'd9, 32'd0, 4'd3);
        serve(0);
        chk("t3_div0", {o_dz, o_z, o_res}, {1'b1, 1'b0, 32'hFFFF_FFFF});

        set_req(1'b0, 32'd3, 32'd4, 4'd2);
        serve(5);
        chk("t4_mul", o_res, 32'd12);

        set_req(1'b0, 32'd5, 32'd6, 4'b1010);
        serve(1);
        chk("t6_sel10", {o_dz, o_z, o_res}, {1'b0, 1'b0, 32'd0});
        set_req(1'b1, 32'd5, 32'd6, 4'd7);
        serve(0);
        chk("t6_nop", {o_dz, o_z, o_res}, {1'b0, 1'b0, 32'd0});

        // Reset during a REQ0 divide drops it and restores the REQ0 tie priority
        set_req(1'b0, 32'd50, 32'd5, 4'd3);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
        chk("t5_rsp_valid", rsp_valid, 1'b0);
        chk("t5_alu_sel", alu_sel, 4'd7);
        for (int c = 0; c < DC + 2; c++) begin
            @(negedge clk);
            chk("t5_no_replay", rsp_valid, 1'b0);
        end
        set_req(1'b0, 32'd1, 32'd2, 4'd5);
        set_req(1'b1, 32'd8, 32'd2, 4'd1);
        serve(0);
        chk("t5_last", o_id, 1'b0);
        serve(0);

        for (int i = 0; i < 40; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (((r == 0) ? !req0_valid : !req1_valid) && $urandom_range(0, 1) == 1) begin
                    set_req(r[0],
                            ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                            ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom_range(0, 1000),
                            ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                        : 4'($urandom_range(0, 7)));
                end
            end
            if (!req0_valid && !req1_valid) set_req(1'b0, $urandom, $urandom, 4'($urandom_range(0, 7)));
            serve($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
